// File: rtl/gerenciador_nos_ativos.sv
// Allocation controller for the active-node cell array: routes each request to the
// cell already holding its address (update) or to the lowest-index free cell (activate).
module gerenciador_nos_ativos #(
  parameter int NUM_SLOTS       = 8,
  parameter int SLOT_WIDTH      = 3,
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_in,
  input  logic                            req_valid_in,
  output logic                            req_ready_out,
  input  logic [ADDR_WIDTH-1:0]           req_endereco_in,
  input  logic [DISTANCIA_WIDTH-1:0]      req_distancia_in,
  input  logic [ADDR_WIDTH-1:0]           req_anterior_in,
  input  logic [NUM_SLOTS-1:0]            slot_ativo_in,
  input  logic [NUM_SLOTS*ADDR_WIDTH-1:0] slot_endereco_in,
  output logic [NUM_SLOTS-1:0]            slot_habilitar_out,
  output logic                            slot_atualizar_out,
  output logic [ADDR_WIDTH-1:0]           slot_endereco_out,
  output logic [DISTANCIA_WIDTH-1:0]      slot_distancia_out,
  output logic [ADDR_WIDTH-1:0]           slot_anterior_out,
  output logic                            hit_out,
  output logic                            full_out,
  output logic [SLOT_WIDTH:0]             num_ativos_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    ISSUE  = 2'd2,
    FULL   = 2'd3
  } estado_t;

  estado_t                      r_estado;
  logic                         r_ready;
  logic [NUM_SLOTS-1:0]         r_habilitar;
  logic                         r_atualizar;
  logic [ADDR_WIDTH-1:0]        r_endereco;
  logic [DISTANCIA_WIDTH-1:0]   r_distancia;
  logic [ADDR_WIDTH-1:0]        r_anterior;
  logic                         r_hit;
  logic                         r_full;
  logic [SLOT_WIDTH:0]          r_num_ativos;
  logic [NUM_SLOTS-1:0]         r_hit_vec;
  logic [NUM_SLOTS-1:0]         r_free_vec;

  logic [NUM_SLOTS-1:0]         w_hit_vec;
  logic [NUM_SLOTS-1:0]         w_free_vec;
  logic [NUM_SLOTS-1:0]         w_hit_onehot;
  logic [NUM_SLOTS-1:0]         w_free_onehot;

  // Isolates the lowest set bit (two's-complement trick)
  function automatic logic [NUM_SLOTS-1:0] menor_bit(input logic [NUM_SLOTS-1:0] v);
    menor_bit = v & (~v + {{(NUM_SLOTS-1){1'b0}}, 1'b1});
  endfunction

  function automatic logic [SLOT_WIDTH:0] contar_ativos(input logic [NUM_SLOTS-1:0] v);
    logic [SLOT_WIDTH:0] c;
    c = {(SLOT_WIDTH+1){1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      c = c + {{SLOT_WIDTH{1'b0}}, v[i]};
    end
    contar_ativos = c;
  endfunction

  // Address match of every active cell against the captured request
  always_comb begin
    w_hit_vec = {NUM_SLOTS{1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_hit_vec[i] = slot_ativo_in[i] &&
                     (slot_endereco_in[i*ADDR_WIDTH +: ADDR_WIDTH] == r_endereco);
    end
  end

  assign w_free_vec    = ~slot_ativo_in;
  assign w_hit_onehot  = menor_bit(w_hit_vec);
  assign w_free_onehot = menor_bit(w_free_vec);

  // Request FSM; cell-facing outputs are loaded at the end of LOOKUP so they are live during ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= IDLE;
      r_ready     <= 1'b1;
      r_habilitar <= {NUM_SLOTS{1'b0}};
      r_atualizar <= 1'b0;
      r_endereco  <= {ADDR_WIDTH{1'b1}};
      r_distancia <= {DISTANCIA_WIDTH{1'b1}};
      r_anterior  <= {ADDR_WIDTH{1'b1}};
      r_hit       <= 1'b0;
      r_full      <= 1'b0;
      r_hit_vec   <= {NUM_SLOTS{1'b0}};
      r_free_vec  <= {NUM_SLOTS{1'b0}};
    end else if (flush_in) begin
      r_estado    <= IDLE;
      r_ready     <= 1'b1;
      r_habilitar <= {NUM_SLOTS{1'b0}};
      r_atualizar <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      case (r_estado)
        IDLE: begin
          r_habilitar <= {NUM_SLOTS{1'b0}};
          r_atualizar <= 1'b0;
          if (req_valid_in && r_ready) begin
            r_endereco  <= req_endereco_in;
            r_distancia <= req_distancia_in;
            r_anterior  <= req_anterior_in;
            r_ready     <= 1'b0;
            r_estado    <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_hit_vec  <= w_hit_vec;
          r_free_vec <= w_free_vec;
          if (|w_hit_vec) begin
            r_habilitar <= w_hit_onehot;
            r_atualizar <= 1'b1;
            r_hit       <= 1'b1;
          end else if (|w_free_vec) begin
            r_habilitar <= w_free_onehot;
            r_atualizar <= 1'b1;
            r_hit       <= 1'b0;
          end else begin
            r_habilitar <= {NUM_SLOTS{1'b0}};
            r_atualizar <= 1'b0;
            r_hit       <= 1'b0;
            r_full      <= 1'b1;
          end
          r_estado <= ISSUE;
        end
        ISSUE: begin
          r_habilitar <= {NUM_SLOTS{1'b0}};
          r_atualizar <= 1'b0;
          if ((|r_hit_vec) || (|r_free_vec)) begin
            r_ready  <= 1'b1;
            r_estado <= IDLE;
          end else begin
            r_estado <= FULL;
          end
        end
        FULL: begin
          r_habilitar <= {NUM_SLOTS{1'b0}};
          r_atualizar <= 1'b0;
          if (|w_free_vec) begin
            r_full   <= 1'b0;
            r_estado <= LOOKUP;
          end
        end
        default: begin
          r_estado    <= IDLE;
          r_ready     <= 1'b1;
          r_habilitar <= {NUM_SLOTS{1'b0}};
          r_atualizar <= 1'b0;
          r_full      <= 1'b0;
        end
      endcase
    end
  end

  // Occupancy count, free-running and unaffected by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_ativos <= {(SLOT_WIDTH+1){1'b0}};
    end else begin
      r_num_ativos <= contar_ativos(slot_ativo_in);
    end
  end

  assign req_ready_out      = r_ready;
  assign slot_habilitar_out = r_habilitar;
  assign slot_atualizar_out = r_atualizar;
  assign slot_endereco_out  = r_endereco;
  assign slot_distancia_out = r_distancia;
  assign slot_anterior_out  = r_anterior;
  assign hit_out            = r_hit;
  assign full_out           = r_full;
  assign num_ativos_out     = r_num_ativos;

endmodule

// File: tb/tb_gerenciador_nos_ativos.sv
// Directed bench for gerenciador_nos_ativos: inputs driven and outputs checked on the falling edge.
module tb_gerenciador_nos_ativos;

  logic        clk;
  logic        rst_n;
  logic        flush_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [4:0]  req_endereco_in;
  logic [4:0]  req_distancia_in;
  logic [4:0]  req_anterior_in;
  logic [7:0]  slot_ativo_in;
  logic [39:0] slot_endereco_in;
  logic [7:0]  slot_habilitar_out;
  logic        slot_atualizar_out;
  logic [4:0]  slot_endereco_out;
  logic [4:0]  slot_distancia_out;
  logic [4:0]  slot_anterior_out;
  logic        hit_out;
  logic        full_out;
  logic [3:0]  num_ativos_out;

  int errors = 0;
  int checks = 0;

  gerenciador_nos_ativos dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush_in           (flush_in),
    .req_valid_in       (req_valid_in),
    .req_ready_out      (req_ready_out),
    .req_endereco_in    (req_endereco_in),
    .req_distancia_in   (req_distancia_in),
    .req_anterior_in    (req_anterior_in),
    .slot_ativo_in      (slot_ativo_in),
    .slot_endereco_in   (slot_endereco_in),
    .slot_habilitar_out (slot_habilitar_out),
    .slot_atualizar_out (slot_atualizar_out),
    .slot_endereco_out  (slot_endereco_out),
    .slot_distancia_out (slot_distancia_out),
    .slot_anterior_out  (slot_anterior_out),
    .hit_out            (hit_out),
    .full_out           (full_out),
    .num_ativos_out     (num_ativos_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready_out}, 32'd1);
    chk({tag, "_hab"},   {24'd0, slot_habilitar_out}, 32'd0);
    chk({tag, "_atu"},   {31'd0, slot_atualizar_out}, 32'd0);
    chk({tag, "_end"},   {27'd0, slot_endereco_out}, 32'h1F);
    chk({tag, "_dist"},  {27'd0, slot_distancia_out}, 32'h1F);
    chk({tag, "_ant"},   {27'd0, slot_anterior_out}, 32'h1F);
    chk({tag, "_hit"},   {31'd0, hit_out}, 32'd0);
    chk({tag, "_full"},  {31'd0, full_out}, 32'd0);
    chk({tag, "_num"},   {28'd0, num_ativos_out}, 32'd0);
  endtask

  initial begin
    logic [7:0] exp_hab;
    rst_n = 1'b0; flush_in = 1'b0; req_valid_in = 1'b0;
    req_endereco_in = 5'd0; req_distancia_in = 5'd0; req_anterior_in = 5'd0;
    slot_ativo_in = 8'd0; slot_endereco_in = 40'd0;
    cyc(2);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    cyc(1);

    // Empty array, miss -> slot 0
    req_valid_in = 1'b1; req_endereco_in = 5'd5; req_distancia_in = 5'd3; req_anterior_in = 5'd1;
    chk("t1_ready_T", {31'd0, req_ready_out}, 32'd1);
    cyc(1);
    req_valid_in = 1'b0;
    chk("t1_ready_T1", {31'd0, req_ready_out}, 32'd0);
    chk("t1_atu_T1", {31'd0, slot_atualizar_out}, 32'd0);
    cyc(1);
    chk("t1_hab", {24'd0, slot_habilitar_out}, 32'h01);
    chk("t1_atu", {31'd0, slot_atualizar_out}, 32'd1);
    chk("t1_hit", {31'd0, hit_out}, 32'd0);
    chk("t1_end", {27'd0, slot_endereco_out}, 32'd5);
    chk("t1_dist", {27'd0, slot_distancia_out}, 32'd3);
    chk("t1_ant", {27'd0, slot_anterior_out}, 32'd1);
    cyc(1);
    chk("t1_atu_off", {31'd0, slot_atualizar_out}, 32'd0);
    chk("t1_hab_off", {24'd0, slot_habilitar_out}, 32'd0);
    chk("t1_ready_back", {31'd0, req_ready_out}, 32'd1);

    // Hit on slot 2 holding address 9
    slot_ativo_in = 8'b00000100;
    slot_endereco_in = 40'd0;
    slot_endereco_in[2*5 +: 5] = 5'd9;
    req_valid_in = 1'b1; req_endereco_in = 5'd9; req_distancia_in = 5'd2; req_anterior_in = 5'd0;
    cyc(1);
    req_valid_in = 1'b0;
    cyc(1);
    chk("t2_hab", {24'd0, slot_habilitar_out}, 32'h04);
    chk("t2_atu", {31'd0, slot_atualizar_out}, 32'd1);
    chk("t2_hit", {31'd0, hit_out}, 32'd1);
    chk("t2_dist", {27'd0, slot_distancia_out}, 32'd2);
    cyc(1);

    // Full array, then slot 6 frees up
    slot_ativo_in = 8'hFF;
    for (int i = 0; i < 8; i++) slot_endereco_in[i*5 +: 5] = 5'(10 + i);
    req_valid_in = 1'b1; req_endereco_in = 5'd30; req_distancia_in = 5'd7; req_anterior_in = 5'd4;
    cyc(1);
    req_valid_in = 1'b0;
    chk("t3_num8", {28'd0, num_ativos_out}, 32'd8);
    cyc(1);
    chk("t3_full_issue", {31'd0, full_out}, 32'd1);
    chk("t3_atu_none", {31'd0, slot_atualizar_out}, 32'd0);
    chk("t3_hab_none", {24'd0, slot_habilitar_out}, 32'd0);
    chk("t3_ready_lo", {31'd0, req_ready_out}, 32'd0);
    cyc(1);
    chk("t3_full_hold", {31'd0, full_out}, 32'd1);
    chk("t3_ready_hold", {31'd0, req_ready_out}, 32'd0);
    slot_ativo_in[6] = 1'b0;
    cyc(1);
    chk("t3_full_clr", {31'd0, full_out}, 32'd0);
    chk("t3_atu_lookup", {31'd0, slot_atualizar_out}, 32'd0);
    cyc(1);
    chk("t3_hab6", {24'd0, slot_habilitar_out}, 32'h40);
    chk("t3_atu6", {31'd0, slot_atualizar_out}, 32'd1);
    chk("t3_hit6", {31'd0, hit_out}, 32'd0);
    cyc(1);
    chk("t3_ready_back", {31'd0, req_ready_out}, 32'd1);

    // Back-to-back with valid held; the bench activates each targeted cell
    slot_ativo_in = 8'd0; slot_endereco_in = 40'd0;
    req_valid_in = 1'b1;
    for (int r = 0; r < 3; r++) begin
      req_endereco_in = 5'(20 + r); req_distancia_in = 5'(r + 1); req_anterior_in = 5'(r);
      chk($sformatf("t4_ready_acc%0d", r), {31'd0, req_ready_out}, 32'd1);
      if (r > 0) chk($sformatf("t4_pulse_end%0d", r), {31'd0, slot_atualizar_out}, 32'd0);
      cyc(1);
      chk($sformatf("t4_ready_lk%0d", r), {31'd0, req_ready_out}, 32'd0);
      chk($sformatf("t4_atu_lk%0d", r), {31'd0, slot_atualizar_out}, 32'd0);
      cyc(1);
      exp_hab = 8'd1 << r;
      chk($sformatf("t4_hab%0d", r), {24'd0, slot_habilitar_out}, {24'd0, exp_hab});
      chk($sformatf("t4_atu%0d", r), {31'd0, slot_atualizar_out}, 32'd1);
      chk($sformatf("t4_end%0d", r), {27'd0, slot_endereco_out}, 32'(20 + r));
      slot_ativo_in = slot_ativo_in | exp_hab;
      slot_endereco_in[r*5 +: 5] = 5'(20 + r);
      cyc(1);
    end
    req_valid_in = 1'b0;
    chk("t4_pulse_end3", {31'd0, slot_atualizar_out}, 32'd0);
    cyc(1);

    // Flush during LOOKUP drops the request
    req_valid_in = 1'b1; req_endereco_in = 5'd25;
    cyc(1);
    req_valid_in = 1'b0; flush_in = 1'b1;
    chk("t5_in_lookup", {31'd0, req_ready_out}, 32'd0);
    cyc(1);
    flush_in = 1'b0;
    chk("t5_ready", {31'd0, req_ready_out}, 32'd1);
    chk("t5_atu", {31'd0, slot_atualizar_out}, 32'd0);
    cyc(1);
    chk("t5_atu_after", {31'd0, slot_atualizar_out}, 32'd0);
    chk("t5_hab_after", {24'd0, slot_habilitar_out}, 32'd0);

    // Reset asserted while in FULL
    slot_ativo_in = 8'hFF;
    for (int i = 0; i < 8; i++) slot_endereco_in[i*5 +: 5] = 5'(i);
    req_valid_in = 1'b1; req_endereco_in = 5'd31;
    cyc(1);
    req_valid_in = 1'b0;
    cyc(2);
    chk("t6_full_pre", {31'd0, full_out}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    cyc(1);
    rst_n = 1'b1;

    // Popcount with one-cycle lag
    slot_ativo_in = 8'b10110010;
    cyc(1);
    chk("t7_num", {28'd0, num_ativos_out}, 32'd4);
    slot_ativo_in = 8'b00000000;
    chk("t7_num_hold", {28'd0, num_ativos_out}, 32'd4);
    cyc(1);
    chk("t7_num_zero", {28'd0, num_ativos_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
